mem_arbiter: RTL

Single-port memory arbiter and access sequencer between the pipeline's instruction-fetch port and its data-memory port. It accepts read requests from fetch and read/write requests from the MEM stage (the `request_dmemREN`/`request_dmemWEN` path decoded by control), and grants one at a time to a shared RAM with variable latency. It also returns a one-cycle hit pulse plus load data to the winning requester, and times out stalled accesses.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the instruction-fetch port and
// the data-memory port. One access is in flight at a time: it is granted in
// IDLE, runs in IACC/DACC until ram_ready or timeout, then pulses a one-cycle
// hit in DONE. Every output is a flop.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between the two sides when both request
//   undefined -> fixed priority, data always beats instruction
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction-fetch side
  input  logic              iREN,
  input  logic [DATA_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  // data-memory side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  // shared RAM
  output logic              ramREN,
  output logic              ramWEN,
  output logic [DATA_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  // status
  output logic              busy,
  output logic              ram_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Last counter value before the access is abandoned: strobes stay up for
  // exactly TIMEOUT cycles when ram_ready never arrives.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            gnt_data;    // granted side: 1 = data, 0 = instruction
  logic            op_write;    // granted operation is a write

  logic            d_req;
  logic            any_req;
  logic            grant;
  logic            pick_data;
  logic            grant_write;
  logic            in_acc;
  logic            acc_ok;
  logic            to_expire;
  logic            finish;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic            last_data;   // side served by the most recent grant
`endif

  // Arbitration between the two requesters while idle.
  // NOTE: always_comb assigns every output first, so no path leaves a value
  // held over from a previous evaluation and no latch is inferred.
  always_comb begin
    d_req   = dREN | dWEN;
    any_req = d_req | iREN;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // A lone requester always wins; on a tie the side not served last wins.
    pick_data = d_req & (~iREN | ~last_data);
`else
    pick_data = d_req;
`endif
    grant       = (state == IDLE) & any_req;
    grant_write = pick_data & dWEN;
  end

  // Access completion and timeout detection for the in-flight access.
  always_comb begin
    in_acc    = (state == IACC) | (state == DACC);
    acc_ok    = in_acc & ram_ready;
    to_expire = in_acc & ~ram_ready & (to_cnt == TO_LAST);
    finish    = acc_ok | to_expire;
  end

  // Next-state selection for the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = pick_data ? DACC : IACC;
      IACC,
      DACC: if (finish) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked blocks use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Timeout counter: zero outside an access, counts cycles without ram_ready.
  always_ff @(posedge CLK) begin
    if (RST)                       to_cnt <= '0;
    else if (!in_acc)              to_cnt <= '0;
    else if (!ram_ready)           to_cnt <= to_cnt + 1'b1;
  end

  // Grant capture: side, operation, address and write data are frozen so
  // that requester changes during the access have no effect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_data <= 1'b0;
      op_write <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else if (grant) begin
      gnt_data <= pick_data;
      op_write <= grant_write;
      ramaddr  <= pick_data ? daddr : iaddr;
      ramstore <= pick_data ? dstore : '0;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember which side received the latest grant.
  always_ff @(posedge CLK) begin
    if (RST)        last_data <= 1'b0;
    else if (grant) last_data <= pick_data;
  end
`endif

  // RAM strobes: raised on grant, held through the access, dropped on finish.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ramREN <= 1'b0;
      ramWEN <= 1'b0;
    end else if (grant) begin
      ramREN <= ~grant_write;
      ramWEN <= grant_write;
    end else if (!in_acc || finish) begin
      ramREN <= 1'b0;
      ramWEN <= 1'b0;
    end
  end

  // Completion pulses: high only for the DONE cycle of the granted side.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ihit <= 1'b0;
      dhit <= 1'b0;
    end else begin
      ihit <= finish & ~gnt_data;
      dhit <= finish &  gnt_data;
    end
  end

  // Load registers: RAM data on success, zero on timeout, held otherwise.
  // A data write leaves dload untouched unless it times out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      iload <= '0;
      dload <= '0;
    end else begin
      if (acc_ok && !gnt_data)                   iload <= ramload;
      else if (to_expire && !gnt_data)           iload <= '0;
      if (acc_ok && gnt_data && !op_write)       dload <= ramload;
      else if (to_expire && gnt_data)            dload <= '0;
    end
  end

  // Status: busy mirrors the next state, ram_error is sticky until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy      <= 1'b0;
      ram_error <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (to_expire) ram_error <= 1'b1;
    end
  end

endmodule
